// File: rtl/pulsar_pkg.sv
// ---------------------------------------------------------------------------
// pulsar_pkg : shared element/address types for the mux and its scan stages
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pulsar_pkg;

  localparam int WIDTH   = 5;
  localparam int NUM_REG = 3;

  function automatic int calc_addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDR_WIDTH = calc_addr_width(NUM_REG);

  typedef logic [WIDTH-1:0]      elem_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_scan_if.sv
// ---------------------------------------------------------------------------
// pwm_scan_if : read port between the double-buffered mux and a scan stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pwm_scan_if
  import pulsar_pkg::*;
#(
  parameter int WIDTH      = pulsar_pkg::WIDTH,
  parameter int ADDR_WIDTH = pulsar_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_latch;
  logic [WIDTH-1:0]      read_data;

  modport master (
    output read_addr,
    output read_latch,
    input  read_data
  );

  modport slave (
    input  read_addr,
    input  read_latch,
    output read_data
  );

endinterface

`default_nettype wire

// File: rtl/pwm_step_counter.sv
// ---------------------------------------------------------------------------
// pwm_step_counter : register-address sweep plus PWM step counter (0..2^W-2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_step_counter
  import pulsar_pkg::*;
#(
  parameter int WIDTH      = pulsar_pkg::WIDTH,
  parameter int NUM_REG    = pulsar_pkg::NUM_REG,
  parameter int ADDR_WIDTH = calc_addr_width(NUM_REG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [WIDTH-1:0]      step_o,
  output logic                  addr_wrap_o,
  output logic                  step_wrap_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_REG - 1);
  localparam logic [WIDTH-1:0]      STEP_LAST = WIDTH'((1 << WIDTH) - 2);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      step_q, step_d;

  assign addr_wrap_o = (addr_q == ADDR_LAST);
  assign step_wrap_o = (step_q == STEP_LAST);

  always_comb begin
    addr_d = addr_q;
    step_d = step_q;
    if (clear) begin
      addr_d = '0;
      step_d = '0;
    end else if (run) begin
      if (addr_wrap_o) begin
        addr_d = '0;
        step_d = step_wrap_o ? '0 : step_q + WIDTH'(1);
      end else begin
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      step_q <= '0;
    end else begin
      addr_q <= addr_d;
      step_q <= step_d;
    end
  end

  assign addr_o = addr_q;
  assign step_o = step_q;

endmodule

`default_nettype wire

// File: rtl/pwm_scan.sv
// ---------------------------------------------------------------------------
// pwm_scan : sweeps the mux read port and turns each value into a PWM bit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_scan
  import pulsar_pkg::*;
#(
  parameter int WIDTH   = pulsar_pkg::WIDTH,
  parameter int NUM_REG = pulsar_pkg::NUM_REG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  pwm_scan_if.master         rd,
  output logic [NUM_REG-1:0] pwm_out,
  output logic               period_start
);

  localparam int                    ADDR_WIDTH = calc_addr_width(NUM_REG);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NUM_REG - 1);

  scan_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_w;
  logic [WIDTH-1:0]      step_w;
  logic                  addr_wrap_w;
  logic                  step_wrap_w;
  logic                  run_w;

  logic                  latch_q, latch_d;
  logic                  tag_valid_q;
  logic [ADDR_WIDTH-1:0] tag_addr_q;
  logic [WIDTH-1:0]      tag_step_q;
  logic [NUM_REG-1:0]    shadow_q, shadow_d;
  logic [NUM_REG-1:0]    pwm_q, pwm_d;
  logic                  ps_q, ps_d;

  // Counters advance only while RUN is held; dropping enable clears them on the same edge.
  assign run_w = (state_q == ST_RUN) && enable;

  pwm_step_counter #(
    .WIDTH      (WIDTH),
    .NUM_REG    (NUM_REG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_step_counter (
    .clk         (clk),
    .rst         (rst),
    .clear       (!run_w),
    .run         (run_w),
    .addr_o      (addr_w),
    .step_o      (step_w),
    .addr_wrap_o (addr_wrap_w),
    .step_wrap_o (step_wrap_w)
  );

  always_comb begin
    state_d  = state_q;
    latch_d  = 1'b0;
    shadow_d = run_w ? shadow_q : '0;
    pwm_d    = run_w ? pwm_q : '0;
    ps_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          latch_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_IDLE;
        else         latch_d = addr_wrap_w && step_wrap_w;
      end
      default: state_d = ST_IDLE;
    endcase

    // The tag lines up with read_data; the last channel publishes the whole vector.
    if (run_w && tag_valid_q) begin
      shadow_d[tag_addr_q] = (rd.read_data > tag_step_q);
      if (tag_addr_q == ADDR_LAST) begin
        pwm_d = shadow_d;
        ps_d  = (tag_step_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      latch_q     <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_addr_q  <= '0;
      tag_step_q  <= '0;
      shadow_q    <= '0;
      pwm_q       <= '0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      latch_q     <= latch_d;
      tag_valid_q <= run_w;
      tag_addr_q  <= addr_w;
      tag_step_q  <= step_w;
      shadow_q    <= shadow_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign rd.read_addr  = addr_w;
  assign rd.read_latch = latch_q;
  assign pwm_out       = pwm_q;
  assign period_start  = ps_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_scan.sv
// ---------------------------------------------------------------------------
// tb_pwm_scan : randomized bench with a step/period reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_scan;
  import pulsar_pkg::*;

  localparam int W    = 5;
  localparam int N    = 3;
  localparam int AW   = pulsar_pkg::ADDR_WIDTH;
  localparam int PER  = (1 << W) - 1;
  localparam int PCYC = N * PER;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] pwm_out;
  logic         period_start;

  always #5 clk = ~clk;

  pwm_scan_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  pwm_scan #(.WIDTH(W), .NUM_REG(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rd           (bus),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Two-bank mux with one-cycle read latency; a latch swaps banks and the same read sees the new bank.
  logic [W-1:0] staged [N];
  logic [W-1:0] active [N];

  always @(posedge clk) begin
    if (bus.read_latch) begin
      for (int i = 0; i < N; i++) active[i] <= staged[i];
      bus.read_data <= staged[bus.read_addr];
    end else begin
      bus.read_data <= active[bus.read_addr];
    end
  end

  // Reference: m counts cycles since enable was sampled; the bank of each period is the staged
  // content at the edge the mux takes the latch.
  bit           running = 1'b0;
  int           m = 0;
  logic [W-1:0] hist [2][N];

  always @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
    end else if (!running) begin
      if (enable) begin
        running <= 1'b1;
        m       <= 0;
      end
    end else if (!enable) begin
      running <= 1'b0;
    end else begin
      m <= m + 1;
      if (m % PCYC == 0)
        for (int i = 0; i < N; i++) hist[(m / PCYC) % 2][i] <= staged[i];
    end
  end

  int           e_addr, e_latch, e_ps, k, s, p;
  logic [N-1:0] e_pwm;

  always @(negedge clk) begin
    e_addr = 0; e_latch = 0; e_ps = 0; e_pwm = '0;
    if (running) begin
      e_addr  = m % N;
      e_latch = (m % PCYC == 0) ? 1 : 0;
      if (m >= N + 1) begin
        k = (m - N - 1) / N;
        s = k % PER;
        p = (k / PER) % 2;
        for (int i = 0; i < N; i++) e_pwm[i] = (int'(hist[p][i]) > s);
        e_ps = (((m - N - 1) % N == 0) && (s == 0)) ? 1 : 0;
      end
    end
    check("read_addr", int'(bus.read_addr), e_addr);
    check("read_latch", int'(bus.read_latch), e_latch);
    check("pwm_out", int'(pwm_out), int'(e_pwm));
    check("period_start", int'(period_start), e_ps);
  end

  int hi0, hi1, hi2, ps_cnt, latch_cnt, first_ps, latch_bad;
  int cyc, act;

  initial begin
    for (int i = 0; i < N; i++) begin
      staged[i] = '0;
      active[i] = '0;
      hist[0][i] = '0;
      hist[1][i] = '0;
    end
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_pwm", int'(pwm_out), 0);
    check("idle_latch", int'(bus.read_latch), 0);

    // Directed period with {0,31,16}; bank rewritten mid-period to {31,0,5}
    staged[0] = 5'd0; staged[1] = 5'd31; staged[2] = 5'd16;
    enable = 1'b1;
    @(posedge clk);
    hi0 = 0; hi1 = 0; hi2 = 0; ps_cnt = 0; latch_cnt = 0; latch_bad = 0; first_ps = -1;
    for (int c = 0; c < 190; c++) begin
      @(negedge clk);
      if (c == 40) begin
        staged[0] = 5'd31; staged[1] = 5'd0; staged[2] = 5'd5;
      end
      if (c < PCYC && bus.read_latch) begin
        latch_cnt++;
        if (bus.read_addr != '0) latch_bad++;
      end
      if (period_start && first_ps < 0) first_ps = c;
      if (c >= 4 && c < 4 + PCYC) begin
        hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
        ps_cnt += int'(period_start);
      end
      if (c == 4 + PCYC - 1) begin
        check("p1_high0", hi0, 0);
        check("p1_high1", hi1, 93);
        check("p1_high2", hi2, 48);
        check("p1_ps_count", ps_cnt, 1);
        hi0 = 0; hi1 = 0; hi2 = 0;
      end
      if (c >= 4 + PCYC) begin
        hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]);
      end
    end
    check("first_ps_latency", first_ps, 4);
    check("latch_per_period", latch_cnt, 1);
    check("latch_addr_zero", latch_bad, 0);
    check("p2_high0", hi0, 93);
    check("p2_high1", hi1, 0);
    check("p2_high2", hi2, 15);

    // Drop enable mid-period, then re-enable
    repeat (17) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("drop_pwm", int'(pwm_out), 0);
    check("drop_latch", int'(bus.read_latch), 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("reen_latch", int'(bus.read_latch), 1);
    check("reen_addr", int'(bus.read_addr), 0);

    // Synchronous reset mid-RUN with enable held high
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_latch", int'(bus.read_latch), 0);
    check("rst_addr", int'(bus.read_addr), 0);
    first_ps = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (period_start && first_ps < 0) first_ps = c;
    end
    check("rst_restart_latency", first_ps, 4);

    // Randomized phase: bank writes, enable drops, reset pulses
    for (int it = 0; it < 40; it++) begin
      cyc = $urandom_range(20, 200);
      for (int c = 0; c < cyc; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 29) == 0) begin
          case ($urandom_range(0, 3))
            0:       staged[$urandom_range(0, N - 1)] = '0;
            1:       staged[$urandom_range(0, N - 1)] = '1;
            default: staged[$urandom_range(0, N - 1)] = W'($urandom);
          endcase
        end
      end
      act = $urandom_range(0, 3);
      if (act == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        enable = 1'b1;
      end else if (act == 1) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
